conv_window_feeder: RTL and testbench



---
 rtl/conv_window_feeder_pkg.sv | 25 ++
 rtl/conv_window_feeder_line_row_buf.sv | 25 ++
 rtl/conv_window_feeder.sv | 168 ++++++++++++++++
 tb/tb_conv_window_feeder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_feeder_pkg.sv
// Shared constants for the 5x5 window feeder: kernel size, FSM encoding and
// slot-pointer arithmetic for the 5-row circular line buffer.
package conv_window_feeder_pkg;

  localparam int K      = 5;
  localparam int SLOT_W = 3;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (base + ofs) mod K, with base < K and ofs < K
  function automatic logic [SLOT_W-1:0] slot_add(input logic [SLOT_W-1:0] base,
                                                 input int ofs);
    logic [SLOT_W:0] s;
    s = {1'b0, base} + (SLOT_W+1)'(ofs);
    if (s >= (SLOT_W+1)'(K)) s = s - (SLOT_W+1)'(K);
    return s[SLOT_W-1:0];
  endfunction

endpackage

// File: rtl/conv_window_feeder_line_row_buf.sv
// One image row of pixel storage: registered write, combinational read.
module conv_window_feeder_line_row_buf
  import conv_window_feeder_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 28,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster-to-column-beat converter: buffers 5 rows, then emits every 5x5 window
// of a band as 5 consecutive column beats while stalling the upstream source.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int data_width = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [data_width-1:0] d_out1,
  output logic [data_width-1:0] d_out2,
  output logic [data_width-1:0] d_out3,
  output logic [data_width-1:0] d_out4,
  output logic [data_width-1:0] d_out5,
  output logic                  out_valid,
  output logic                  band_done,
  output logic                  frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int BW = cnt_w(IMG_H);
  localparam logic [CW-1:0]     COL_MAX  = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     WIN_MAX  = CW'(IMG_W - K);
  localparam logic [BW-1:0]     BAND_MAX = BW'(IMG_H - K);
  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(K - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         wr_col_q, wr_col_d, col_q, col_d;
  logic [SLOT_W-1:0]     row_cnt_q, row_cnt_d, top_ptr_q, top_ptr_d, beat_q, beat_d;
  logic [BW-1:0]         band_q, band_d;
  logic                  pix_ready_q, out_valid_q, out_valid_d;
  logic                  band_done_q, band_done_d, frame_done_q, frame_done_d;
  logic [data_width-1:0] dout_q [K];
  logic [data_width-1:0] dout_d [K];
  logic [data_width-1:0] rd_data [K];

  logic              accept, row_wrap, last_beat;
  logic [CW-1:0]     rd_col;
  logic [SLOT_W-1:0] wr_slot;

  assign accept    = pix_valid && pix_ready_q;
  assign row_wrap  = accept && (wr_col_q == COL_MAX);
  assign last_beat = (state_q == ST_EMIT) && (col_q == WIN_MAX) && (beat_q == LAST_IDX);
  assign rd_col    = col_q + CW'(beat_q);
  // FILL writes rows in arrival order; LOAD recycles the oldest slot
  assign wr_slot   = (state_q == ST_LOAD) ? top_ptr_q : row_cnt_q;

  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    conv_window_feeder_line_row_buf #(
      .DW   (data_width),
      .DEPTH(IMG_W),
      .AW   (CW)
    ) u_line_row_buf (
      .clk      (clk),
      .wr_en_i  (accept && (wr_slot == SLOT_W'(gi))),
      .wr_addr_i(wr_col_q),
      .wr_data_i(pix_in),
      .rd_addr_i(rd_col),
      .rd_data_o(rd_data[gi])
    );
  end

  always_comb begin
    state_d      = state_q;
    wr_col_d     = wr_col_q;
    col_d        = col_q;
    row_cnt_d    = row_cnt_q;
    top_ptr_d    = top_ptr_q;
    beat_d       = beat_q;
    band_d       = band_q;
    out_valid_d  = 1'b0;
    band_done_d  = 1'b0;
    frame_done_d = 1'b0;
    for (int i = 0; i < K; i++) dout_d[i] = dout_q[i];

    case (state_q)
      ST_FILL: begin
        if (accept) wr_col_d = row_wrap ? '0 : wr_col_q + 1'b1;
        if (row_wrap) begin
          if (row_cnt_q == LAST_IDX) begin
            row_cnt_d = '0;
            state_d   = ST_EMIT;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) wr_col_d = row_wrap ? '0 : wr_col_q + 1'b1;
        if (row_wrap) begin
          top_ptr_d = slot_add(top_ptr_q, 1);
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid_d = 1'b1;
        for (int i = 0; i < K; i++) dout_d[i] = rd_data[slot_add(top_ptr_q, i)];
        if (beat_q == LAST_IDX) begin
          beat_d = '0;
          col_d  = col_q + 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
        if (last_beat) begin
          col_d       = '0;
          band_done_d = 1'b1;
          if (band_q == BAND_MAX) begin
            frame_done_d = 1'b1;
            band_d       = '0;
            top_ptr_d    = '0;
            row_cnt_d    = '0;
            state_d      = ST_FILL;
          end else begin
            band_d  = band_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      wr_col_q     <= '0;
      col_q        <= '0;
      row_cnt_q    <= '0;
      top_ptr_q    <= '0;
      beat_q       <= '0;
      band_q       <= '0;
      pix_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      band_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < K; i++) dout_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      col_q        <= col_d;
      row_cnt_q    <= row_cnt_d;
      top_ptr_q    <= top_ptr_d;
      beat_q       <= beat_d;
      band_q       <= band_d;
      pix_ready_q  <= (state_d != ST_EMIT);
      out_valid_q  <= out_valid_d;
      band_done_q  <= band_done_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < K; i++) dout_q[i] <= dout_d[i];
    end
  end

  assign pix_ready  = pix_ready_q;
  assign out_valid  = out_valid_q;
  assign band_done  = band_done_q;
  assign frame_done = frame_done_q;
  assign d_out1     = dout_q[0];
  assign d_out2     = dout_q[1];
  assign d_out3     = dout_q[2];
  assign d_out4     = dout_q[3];
  assign d_out5     = dout_q[4];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on an 8x7 image with pixel = row*16+col.
module tb_conv_window_feeder;

  localparam int IMG_W = 8;
  localparam int IMG_H = 7;
  localparam int NBEAT = (IMG_H - 4) * (IMG_W - 4) * 5;

  logic        clk;
  logic        rst_n;
  logic [15:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] d_out1, d_out2, d_out3, d_out4, d_out5;
  logic        out_valid, band_done, frame_done;

  typedef struct {
    logic [79:0] data;
    logic        bd;
    logic        fd;
    int          stamp;
  } beat_t;

  beat_t beats[$];
  int    checks = 0;
  int    errors = 0;
  int    accepts = 0;
  int    cyc = 0;

  conv_window_feeder #(
    .data_width(16),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .d_out1    (d_out1),
    .d_out2    (d_out2),
    .d_out3    (d_out3),
    .d_out4    (d_out4),
    .d_out5    (d_out5),
    .out_valid (out_valid),
    .band_done (band_done),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (out_valid)
      beats.push_back('{data: {d_out1, d_out2, d_out3, d_out4, d_out5},
                        bd: band_done, fd: frame_done, stamp: cyc});
    if (pix_valid && pix_ready) accepts++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int kern(input int r, input int c);
    return ((r * 5 + c) % 7) - 3;
  endfunction

  function automatic logic [79:0] exp_data(input int b, input int j);
    logic [79:0] r;
    int x, k;
    x = j / 5;
    k = j % 5;
    for (int i = 0; i < 5; i++) r[79-16*i -: 16] = 16'((b + i) * 16 + x + k);
    return r;
  endfunction

  task automatic send_pix(input logic [15:0] v, input bit bub);
    int n;
    if (bub && $urandom_range(0, 2) == 0) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    pix_in    = v;
    pix_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pix_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout observed pix_ready stuck low expected ready");
    end
    @(posedge clk);
    #1;
    // in bubble mode keep valid high with junk so EMIT must ignore it
    if (bub) pix_in = 16'hBEEF;
    else pix_valid = 1'b0;
  endtask

  task automatic send_row(input int r, input bit bub);
    for (int c = 0; c < IMG_W; c++) send_pix(16'(r * 16 + c), bub);
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k;
    k = 0;
    while (beats.size() < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(tag, 128'(k < 2000), 128'(1));
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = beats.size();
    chk({tag, "_count"}, 128'(n), 128'(NBEAT));
    if (n > NBEAT) n = NBEAT;
    for (int i = 0; i < n; i++) begin
      int  b, j;
      logic contig;
      b = i / 20;
      j = i % 20;
      contig = 1'b1;
      if (j != 0) contig = (beats[i].stamp == beats[i-1].stamp + 1);
      chk($sformatf("%s_beat%0d", tag, i),
          {beats[i].data, beats[i].bd, beats[i].fd, contig},
          {exp_data(b, j), (j == 19), (i == NBEAT - 1), 1'b1});
    end
    for (int w = 0; w < n / 5; w++) begin
      int b, x, so, se;
      b = w / (IMG_W - 4);
      x = w % (IMG_W - 4);
      so = 0;
      se = 0;
      for (int k = 0; k < 5; k++)
        for (int r = 0; r < 5; r++) begin
          so += kern(r, k) * int'(beats[w*5+k].data[79-16*r -: 16]);
          se += kern(r, k) * ((b + r) * 16 + x + k);
        end
      chk($sformatf("%s_conv%0d", tag, w), 128'(so), 128'(se));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(pix_ready), 128'(0));
    chk("rst_outs", {out_valid, band_done, frame_done, d_out1, d_out2, d_out3, d_out4, d_out5}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("fill_ready", 128'(pix_ready), 128'(1));

    // Frame A: gap-free, with latency checks around the first window
    beats.delete();
    accepts = 0;
    for (int r = 0; r < 5; r++) send_row(r, 1'b0);
    chk("ready_drop", {pix_ready, out_valid}, '0);
    @(posedge clk);
    #1;
    chk("first_beat", {out_valid, d_out1, d_out2, d_out3, d_out4, d_out5},
        {1'b1, 16'h00, 16'h10, 16'h20, 16'h30, 16'h40});
    send_row(5, 1'b0);
    send_row(6, 1'b0);
    wait_beats(NBEAT, "A_wait");
    repeat (3) @(posedge clk);
    #1;
    chk("A_ready_fill", 128'(pix_ready), 128'(1));
    chk("A_idle_valid", 128'(out_valid), 128'(0));
    chk("A_accepts", 128'(accepts), 128'(IMG_W * IMG_H));
    check_frame("A");

    // Frame B: upstream bubbles and valid held high during EMIT
    beats.delete();
    accepts = 0;
    for (int r = 0; r < IMG_H; r++) send_row(r, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    wait_beats(NBEAT, "B_wait");
    repeat (3) @(posedge clk);
    #1;
    chk("B_accepts", 128'(accepts), 128'(IMG_W * IMG_H));
    check_frame("B");

    // Frame C: reset in the middle of band 1
    beats.delete();
    for (int r = 0; r < 6; r++) send_row(r, 1'b0);
    wait_beats(28, "C_wait");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {pix_ready, out_valid, band_done, frame_done,
                        d_out1, d_out2, d_out3, d_out4, d_out5}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    beats.delete();
    accepts = 0;
    @(posedge clk);
    #1;

    // Frame D: full frame after the reset must match the reference
    for (int r = 0; r < IMG_H; r++) send_row(r, 1'b0);
    wait_beats(NBEAT, "D_wait");
    repeat (3) @(posedge clk);
    #1;
    chk("D_ready_fill", 128'(pix_ready), 128'(1));
    check_frame("D");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
